// File: rtl/fetch_byte_source.sv
// fetch_byte_source
//   Producer side of the instruction byte stream. Owns the fetch PC, issues
//   single-byte reads on a req/gnt/rvalid bus (one outstanding at most),
//   buffers the returned bytes in a DEPTH-entry FIFO tagged with their address,
//   and presents the head entry to the fetch stage over valid/ready.
//   A redirect flushes the FIFO, restarts at redirect_pc_i and drops any
//   in-flight response.
//
//   state | meaning
//   IDLE  | no request; waiting for FIFO space
//   REQ   | mem_req_o=1, mem_addr_o=fetch_pc
//   WAIT  | read granted, awaiting mem_rvalid_i
//
// Ports
//   clk_i, rstn_i              clock, async active-low reset
//   mem_req_o/addr_o/gnt_i     read request channel
//   mem_rvalid_i/rdata_i       read response channel
//   redirect_i/redirect_pc_i   flush and restart
//   byte_o/byte_pc_o           head byte and its address
//   byte_valid_o/byte_ready_i  handshake to the fetch stage
module fetch_byte_source #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h8000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [7:0]  mem_rdata_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic [7:0]  byte_o,
  output logic [15:0] byte_pc_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e         state_q, state_d;
  logic [15:0]    fetch_pc_q, fetch_pc_d;
  logic [15:0]    req_pc_q, req_pc_d;
  logic           drop_q, drop_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [23:0]    mem_q [DEPTH];

  logic           push, pop;
  logic [CW-1:0]  count_post;

  assign byte_valid_o = (count_q != '0);
  assign pop          = byte_valid_o && byte_ready_i && !redirect_i;
  assign push         = (state_q == S_WAIT) && mem_rvalid_i && !drop_q && !redirect_i;
  assign count_post   = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    count_d    = count_post;
    head_d     = pop  ? head_q + AW'(1) : head_q;
    tail_d     = push ? tail_q + AW'(1) : tail_q;

    // A request is only launched with a free slot, and the slot stays
    // reserved until the response arrives (pops only free more space),
    // so a push can never find the FIFO full.
    case (state_q)
      S_IDLE: if (count_q < CW'(DEPTH)) state_d = S_REQ;
      S_REQ: begin
        if (mem_gnt_i) begin
          state_d    = S_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          drop_d  = 1'b0;
          state_d = (count_post < CW'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_i) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc_i;
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  if (mem_gnt_i) drop_d = 1'b1;  // read still issued; its data is stale
        S_WAIT: begin
          if (mem_rvalid_i) state_d = S_REQ;
          else              drop_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Storage is not reset; outputs are gated by byte_valid_o instead.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[tail_q] <= {mem_rdata_i, req_pc_q};
  end

  assign mem_req_o  = (state_q == S_REQ);
  assign mem_addr_o = mem_req_o ? fetch_pc_q : 16'h0000;

  always_comb begin
    byte_o    = 8'h00;
    byte_pc_o = 16'h0000;
    if (byte_valid_o) {byte_o, byte_pc_o} = mem_q[head_q];
  end

endmodule

// File: tb/tb_fetch_byte_source.sv
module tb_fetch_byte_source;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic [7:0]  byte_o;
  logic [15:0] byte_pc_o;
  logic        byte_valid_o;
  logic        byte_ready_i;

  fetch_byte_source #(.DEPTH(4), .RESET_PC(16'h8000)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .byte_o(byte_o), .byte_pc_o(byte_pc_o), .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // program memory contents
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h8000: return 8'hA9;
      16'h8001: return 8'h01;
      16'h8002: return 8'h8D;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory responder state
  int          r_gnt_lat = 0, r_rv_lat = 1, r_gwait = 0, r_rv_cnt = 0;
  logic        r_pend = 1'b0;
  logic [15:0] r_addr = '0;
  logic        req_prev = 1'b0;
  logic [15:0] addr_prev = '0;
  logic        force_rv = 1'b0;
  logic [15:0] gnt_q[$];

  // reference stream model: bytes leave in address order from the last restart
  logic [15:0] exp_pc = 16'h8000;
  logic [7:0]  pop_b_q[$];
  logic [15:0] pop_pc_q[$];
  int          cyc = 0;

  // One clock: observe/drive at the falling edge, return 1 ns after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rstn_i) begin
      if (byte_valid_o) begin
        chk("head_pc", {16'h0, byte_pc_o}, {16'h0, exp_pc});
        chk("head_byte", {24'h0, byte_o}, {24'h0, mem_byte(exp_pc)});
      end
      if (redirect_i) exp_pc = redirect_pc_i;
      else if (byte_valid_o && byte_ready_i) begin
        pop_b_q.push_back(byte_o);
        pop_pc_q.push_back(byte_pc_o);
        exp_pc = exp_pc + 16'd1;
      end
    end
    if (mem_rvalid_i) r_pend = 1'b0;
    if (mem_gnt_i && req_prev && rstn_i) begin
      r_pend = 1'b1; r_addr = addr_prev; r_rv_cnt = r_rv_lat;
      gnt_q.push_back(addr_prev);
    end
    if (!rstn_i) r_pend = 1'b0;
    req_prev  = mem_req_o;
    addr_prev = mem_addr_o;
    mem_gnt_i = 1'b0;
    if (req_prev) begin
      if (r_gwait >= r_gnt_lat) begin mem_gnt_i = 1'b1; r_gwait = 0; end
      else r_gwait++;
    end else r_gwait = 0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 8'h00;
    if (r_pend) begin
      r_rv_cnt--;
      if (r_rv_cnt == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = mem_byte(r_addr); end
    end else if (force_rv) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 8'hEE; force_rv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_b_q.delete(); pop_pc_q.delete(); gnt_q.delete();
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    exp_pc = 16'h8000;
    step(); step();
    clear_logs();
    rstn_i = 1'b1;
  endtask

  task automatic wait_pops(input int n, input string name);
    int k = 0;
    while (pop_b_q.size() < n && k < 200) begin step(); k++; end
    if (pop_b_q.size() < n) chk(name, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [15:0] pc;
    int          gnt_lat;
    int          rv_lat;
    int          n;
    logic [7:0]  exp_b0;
    logic [15:0] exp_last_pc;
  } vec_t;

  vec_t vecs[4];
  logic [7:0]  exp_a_b[3];
  logic [15:0] exp_a_pc[3];

  initial begin
    int first_req, first_valid, k;
    logic seen;

    vecs[0] = '{16'h1234, 0, 1, 4, 8'h7C, 16'h1237};
    vecs[1] = '{16'hFFFE, 1, 2, 3, 8'h5B, 16'h0000};
    vecs[2] = '{16'hC000, 2, 1, 2, 8'h9A, 16'hC001};
    vecs[3] = '{16'h8000, 0, 3, 3, 8'hA9, 16'h8002};
    exp_a_b  = '{8'hA9, 8'h01, 8'h8D};
    exp_a_pc = '{16'h8000, 16'h8001, 16'h8002};

    rstn_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 8'h00;
    redirect_i = 1'b0; redirect_pc_i = 16'h0; byte_ready_i = 1'b0;
    step(); step();
    chk("rst_req", {31'h0, mem_req_o}, 32'd0);
    chk("rst_addr", {16'h0, mem_addr_o}, 32'd0);
    chk("rst_valid", {31'h0, byte_valid_o}, 32'd0);
    chk("rst_byte", {24'h0, byte_o}, 32'd0);
    chk("rst_pc", {16'h0, byte_pc_o}, 32'd0);

    // A: first bytes after reset, latency from first request
    byte_ready_i = 1'b1;
    clear_logs();
    rstn_i = 1'b1;
    first_req = -1; first_valid = -1; k = 0;
    while (pop_b_q.size() < 3 && k < 40) begin
      step(); k++;
      if (mem_req_o && first_req < 0) first_req = cyc;
      if (byte_valid_o && first_valid < 0) first_valid = cyc;
    end
    if (pop_b_q.size() < 3) chk("a_timeout", 32'd0, 32'd1);
    // valid in the third cycle counting the first request cycle as one
    chk("a_latency", first_valid - first_req, 32'd2);
    for (int i = 0; i < 3 && i < pop_b_q.size(); i++) begin
      chk("a_byte", {24'h0, pop_b_q[i]}, {24'h0, exp_a_b[i]});
      chk("a_pc", {16'h0, pop_pc_q[i]}, {16'h0, exp_a_pc[i]});
    end

    // B: back-pressure fills exactly DEPTH entries, then drains and resumes
    byte_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 30; i++) step();
    chk("b_grants", gnt_q.size(), 32'd4);
    chk("b_req_idle", {31'h0, mem_req_o}, 32'd0);
    chk("b_hold_valid", {31'h0, byte_valid_o}, 32'd1);
    chk("b_hold_byte", {24'h0, byte_o}, 32'hA9);
    byte_ready_i = 1'b1;
    wait_pops(4, "b_drain_timeout");
    for (int i = 0; i < 4 && i < pop_pc_q.size(); i++)
      chk("b_drain_pc", {16'h0, pop_pc_q[i]}, 32'h8000 + i);
    k = 0;
    while (gnt_q.size() < 5 && k < 20) begin step(); k++; end
    if (gnt_q.size() >= 5) chk("b_resume_addr", {16'h0, gnt_q[4]}, 32'h8004);
    else chk("b_resume_timeout", 32'd0, 32'd1);

    // C: redirect while waiting for a slow response
    r_rv_lat = 3;
    k = 0;
    while (!(r_pend && r_rv_cnt == 2) && k < 40) begin step(); k++; end
    redirect_i = 1'b1; redirect_pc_i = 16'hC000;
    step();
    redirect_i = 1'b0;
    seen = 1'b0; k = 0;
    while (!seen && k < 30) begin
      step(); k++;
      if (byte_valid_o) seen = 1'b1;
    end
    chk("c_seen", {31'h0, seen}, 32'd1);
    chk("c_first_pc", {16'h0, byte_pc_o}, 32'hC000);

    // D: redirect on the same edge as rvalid and a pop, two bytes buffered
    r_rv_lat = 2; byte_ready_i = 1'b0;
    do_reset();
    k = 0;
    while (!(gnt_q.size() == 3 && r_pend && r_rv_cnt == 1) && k < 40) begin step(); k++; end
    chk("d_pre_valid", {31'h0, byte_valid_o}, 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 16'hC000; byte_ready_i = 1'b1;
    step();
    redirect_i = 1'b0;
    chk("d_flushed", {31'h0, byte_valid_o}, 32'd0);
    k = 0;
    while (!mem_req_o && k < 10) begin step(); k++; end
    chk("d_next_addr", {16'h0, mem_addr_o}, 32'hC000);

    // E: table of restarts
    foreach (vecs[v]) begin
      r_gnt_lat = vecs[v].gnt_lat; r_rv_lat = vecs[v].rv_lat; byte_ready_i = 1'b1;
      redirect_i = 1'b1; redirect_pc_i = vecs[v].pc;
      step();
      redirect_i = 1'b0;
      clear_logs();
      wait_pops(vecs[v].n, "e_timeout");
      if (pop_b_q.size() >= vecs[v].n) begin
        chk("e_first_byte", {24'h0, pop_b_q[0]}, {24'h0, vecs[v].exp_b0});
        chk("e_first_pc", {16'h0, pop_pc_q[0]}, {16'h0, vecs[v].pc});
        chk("e_last_pc", {16'h0, pop_pc_q[vecs[v].n-1]}, {16'h0, vecs[v].exp_last_pc});
      end
    end

    // F: random traffic against the stream model
    clear_logs();
    for (int i = 0; i < 1500; i++) begin
      byte_ready_i = ($urandom_range(0, 3) != 0);
      r_gnt_lat = $urandom_range(0, 2);
      r_rv_lat  = $urandom_range(1, 3);
      redirect_i = ($urandom_range(0, 49) == 0);
      redirect_pc_i = 16'($urandom);
      step();
    end
    redirect_i = 1'b0;
    checks++;
    if (pop_b_q.size() < 50) begin
      errors++;
      $display("FAIL f_progress: got %0d bytes expected at least 50", pop_b_q.size());
    end

    // G: asynchronous reset mid-WAIT, stale rvalid during and after reset
    r_gnt_lat = 0; r_rv_lat = 3; byte_ready_i = 1'b1;
    k = 0;
    while (!(r_pend && r_rv_cnt == 2) && k < 40) begin step(); k++; end
    #2 rstn_i = 1'b0;
    exp_pc = 16'h8000;
    #1;
    chk("g_req", {31'h0, mem_req_o}, 32'd0);
    chk("g_addr", {16'h0, mem_addr_o}, 32'd0);
    chk("g_valid", {31'h0, byte_valid_o}, 32'd0);
    chk("g_byte", {24'h0, byte_o}, 32'd0);
    chk("g_pc", {16'h0, byte_pc_o}, 32'd0);
    force_rv = 1'b1;
    step(); step();
    clear_logs();
    force_rv = 1'b1;
    rstn_i = 1'b1;
    k = 0;
    while (!mem_req_o && k < 10) begin step(); k++; end
    chk("g_first_addr", {16'h0, mem_addr_o}, 32'h8000);
    wait_pops(2, "g_timeout");
    if (pop_b_q.size() >= 2) chk("g_first_byte", {24'h0, pop_b_q[0]}, 32'hA9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
